// File: rtl/frame_draw_sched.sv
//------------------------------------------------------------------------------
// frame_draw_sched
// Per-frame draw scheduler: on vertical blank runs the map drawer over the
// frame, then the sprite drawer once per enabled slot in index order, and
// routes the single frame-buffer write port to whichever engine is active.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module frame_draw_sched #(
  parameter int ADDR_W  = 19,
  parameter int NUM_SPR = 8,
  parameter int IDX_W   = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              vsync_start_i,
  input  logic [ADDR_W-1:0] map_base_i,
  input  logic [NUM_SPR-1:0] spr_en_i,
  output logic              map_start_o,
  output logic [ADDR_W-1:0] map_base_addr_o,
  input  logic              map_done_i,
  output logic              spr_start_o,
  output logic [IDX_W-1:0]  spr_idx_o,
  input  logic              spr_done_i,
  input  logic              map_we_i,
  input  logic [ADDR_W-1:0] map_addr_i,
  input  logic [31:0]       map_data_i,
  input  logic              spr_we_i,
  input  logic [ADDR_W-1:0] spr_addr_i,
  input  logic [31:0]       spr_data_i,
  output logic              map_frame_rdy_o,
  output logic              spr_frame_rdy_o,
  output logic              fb_we_o,
  output logic [ADDR_W-1:0] fb_addr_o,
  output logic [31:0]       fb_data_o,
  input  logic              fb_rdy_i,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              overrun_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MAP_GO   = 3'd1,
    S_MAP_WAIT = 3'd2,
    S_SCAN     = 3'd3,
    S_SPR_GO   = 3'd4,
    S_SPR_WAIT = 3'd5,
    S_FIN      = 3'd6
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPR - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [NUM_SPR-1:0] en_q;
  logic [ADDR_W-1:0]  base_q;
  logic [IDX_W-1:0]   spr_idx_q;
  logic               map_start_q;
  logic               spr_start_q;
  logic               busy_q;
  logic               frame_done_q;
  logic               overrun_q;

  logic map_own;
  logic spr_own;

  // Sequencer: walks map phase then sprite slots; control outputs are
  // registered alongside the state so they change only on clock edges.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      en_q         <= '0;
      base_q       <= '0;
      spr_idx_q    <= '0;
      map_start_q  <= 1'b0;
      spr_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      map_start_q  <= 1'b0;
      spr_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      // A new frame request while still composing is flagged, never queued.
      overrun_q    <= vsync_start_i && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (vsync_start_i) begin
            base_q      <= map_base_i;
            en_q        <= spr_en_i;
            ptr_q       <= '0;
            state_q     <= S_MAP_GO;
            map_start_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_MAP_GO: state_q <= S_MAP_WAIT;
        S_MAP_WAIT: begin
          if (map_done_i) begin
            ptr_q   <= '0;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          // The last-slot exit is tested before incrementing, so ptr never wraps.
          if (en_q[ptr_q]) begin
            state_q     <= S_SPR_GO;
            spr_start_q <= 1'b1;
            spr_idx_q   <= ptr_q;
          end else if (ptr_q == LAST_IDX) begin
            state_q      <= S_FIN;
            frame_done_q <= 1'b1;
          end else begin
            ptr_q <= ptr_q + IDX_W'(1);
          end
        end
        S_SPR_GO: state_q <= S_SPR_WAIT;
        S_SPR_WAIT: begin
          if (spr_done_i) begin
            if (ptr_q == LAST_IDX) begin
              state_q      <= S_FIN;
              frame_done_q <= 1'b1;
            end else begin
              ptr_q   <= ptr_q + IDX_W'(1);
              state_q <= S_SCAN;
            end
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Write-port owner decode and mux; non-owner requests are dropped.
  always_comb begin
    map_own         = (state_q == S_MAP_GO) || (state_q == S_MAP_WAIT);
    spr_own         = (state_q == S_SPR_GO) || (state_q == S_SPR_WAIT);
    fb_we_o         = 1'b0;
    fb_addr_o       = '0;
    fb_data_o       = '0;
    map_frame_rdy_o = map_own & fb_rdy_i;
    spr_frame_rdy_o = spr_own & fb_rdy_i;
    if (map_own) begin
      fb_we_o   = map_we_i;
      fb_addr_o = map_addr_i;
      fb_data_o = map_data_i;
    end else if (spr_own) begin
      fb_we_o   = spr_we_i;
      fb_addr_o = spr_addr_i;
      fb_data_o = spr_data_i;
    end
  end

  assign map_start_o     = map_start_q;
  assign map_base_addr_o = base_q;
  assign spr_start_o     = spr_start_q;
  assign spr_idx_o       = spr_idx_q;
  assign busy_o          = busy_q;
  assign frame_done_o    = frame_done_q;
  assign overrun_o       = overrun_q;

endmodule

`default_nettype wire

// File: doc/frame_draw_sched.md
# frame_draw_sched

Per-frame scheduler for the frame-buffer draw engines. On each vertical-blank pulse it runs the map drawer over the full 640x480 frame, then runs the sprite drawer once for each enabled sprite slot in index order. It owns the single frame-buffer write port and routes it to whichever engine is active. It sits between the VGA timing block, the map/sprite draw engines and the frame buffer.

## Interface
- ADDR_W, 19, frame/map address width
- NUM_SPR, 8, number of sprite slots
- IDX_W, 3, sprite index width, equal to clog2(NUM_SPR)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- vsync_start  in  1  single-cycle pulse at start of vertical blank
- map_base  in  ADDR_W  map image base address, sampled on accepted vsync_start
- spr_en  in  NUM_SPR  sprite enable mask, sampled on accepted vsync_start
- map_start  out  1  one-cycle start pulse to the map drawer
- map_base_addr  out  ADDR_W  latched map_base, stable while busy
- map_done  in  1  map drawer completion pulse
- spr_start  out  1  one-cycle start pulse to the sprite drawer
- spr_idx  out  IDX_W  current sprite slot, stable from spr_start until spr_done
- spr_done  in  1  sprite drawer completion pulse
- map_we, map_addr[ADDR_W], map_data[32]  in  map drawer frame-write request
- spr_we, spr_addr[ADDR_W], spr_data[32]  in  sprite drawer frame-write request
- map_frame_rdy, spr_frame_rdy  out  1  fb_rdy gated to the port owner
- fb_we  out  1, fb_addr  out  ADDR_W, fb_data  out  32  frame-buffer write port
- fb_rdy  in  1  frame buffer accepts a write this cycle
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse when composition completes
- overrun  out  1  one-cycle pulse when vsync_start arrives while busy

## Operation
- States: IDLE, MAP_GO, MAP_WAIT, SCAN, SPR_GO, SPR_WAIT, FIN.
- IDLE: on vsync_start, latch map_base and spr_en, clear ptr to 0, go to MAP_GO.
- MAP_GO: map_start=1 for this cycle only. Go to MAP_WAIT.
- MAP_WAIT: on map_done, go to SCAN with ptr=0.
- SCAN: tests one slot per cycle.
  - If en_q[ptr]=1, go to SPR_GO.
  - Else if ptr=NUM_SPR-1, go to FIN.
  - Else increment ptr.
- SPR_GO: spr_start=1 and spr_idx=ptr. Go to SPR_WAIT.
- SPR_WAIT: on spr_done, go to FIN if ptr=NUM_SPR-1; otherwise increment ptr and go to SCAN.
- FIN: frame_done=1 for this cycle. Go to IDLE.
- Port ownership: map owns the port in MAP_GO/MAP_WAIT; sprite owns it in SPR_GO/SPR_WAIT; no owner otherwise.
  - Owner's we/addr/data pass combinationally to fb_*.
  - Owner's frame_rdy equals fb_rdy. Non-owner's frame_rdy is 0.
  - Non-owner writes are dropped. With no owner, fb_we=0, fb_addr=0, fb_data=0.
- map_done is ignored outside MAP_WAIT; spr_done is ignored outside SPR_WAIT.
- vsync_start in any state other than IDLE pulses overrun the next cycle. The current frame continues and the latched values are unchanged. vsync_start is accepted again only in IDLE; vsync_start during FIN is an overrun.
- All pointer arithmetic is IDX_W wide. ptr never wraps because the ptr=NUM_SPR-1 exit is tested first.

## Timing
- Reset (asynchronous): state IDLE, ptr 0, latches 0. All outputs are 0: map_start, spr_start, spr_idx, map_base_addr, fb_*, both frame_rdy, busy, frame_done, overrun.
- All control outputs are registered-state decodes; fb_* and frame_rdy are combinational muxes.
- vsync_start sampled at edge k gives map_start high in cycle k+1 and busy high from cycle k+1.
- map_done at edge m gives the first SCAN cycle at m+1.
- Each disabled slot costs one SCAN cycle. Each enabled slot costs one SCAN cycle, one SPR_GO cycle, and its drawer time.
- Mask 0, map_done at m: frame_done in cycle m+NUM_SPR+1, IDLE at m+NUM_SPR+2.
- spr_done at edge d for the last slot: frame_done in cycle d+1.
- Reset mid-frame aborts immediately with all outputs 0. Drawers are reset by the same rst_n.

## Test plan
- Reset mid-MAP_WAIT -> all outputs 0 asynchronously; next vsync_start with map_base=0x12C00 -> map_start one cycle later, map_base_addr=0x12C00.
- spr_en=8'b0000_0000, map_done 100 cycles after map_start -> no spr_start; frame_done exactly 9 cycles after map_done; busy falls the following cycle.
- spr_en=8'b1000_0101 -> spr_start three times with spr_idx 0, 2, 7 in order, each only after the prior spr_done; frame_done 1 cycle after the third spr_done.
- Map phase, map_we=1, addr=307199, data=0xDEADBEEF, fb_rdy=1; concurrent spr_we=1 -> fb gets map values, map_frame_rdy=1, spr_frame_rdy=0. In SPR_WAIT the roles reverse.
- vsync_start pulsed during SPR_WAIT with a new map_base -> overrun one cycle later; map_base_addr unchanged; no extra map_start; frame completes normally.
- map_done pulsed while IDLE, and spr_done pulsed during MAP_WAIT -> state unchanged, no spurious starts or frame_done.
